// File: rtl/wb_sched_pkg.sv
// Shared types for the writeback slot scheduler: slot entry layout and default latencies.
// Slot fields are sized for the widest supported dest/src; DEST_SIZE must not exceed SLOT_DEST_W.
package wb_sched_pkg;
  localparam int SLOT_DEST_W     = 8;
  localparam int SLOT_SRC_W      = 4;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_LATENCY [DEFAULT_NUM_REQ] = '{1, 2, 3, 4};

  typedef struct packed {
    logic                   valid;
    logic [SLOT_DEST_W-1:0] dest;
    logic [SLOT_SRC_W-1:0]  src;
  } slot_entry;
endpackage

// File: rtl/wb_slot_arbiter_rr_arbiter.sv
// Round-robin one-hot selector: the first eligible requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_slot_arbiter.sv
// Fixed-latency writeback slot arbiter with round-robin issue grant and RAW scoreboard query.
// Optional macro WB_SLOT_ARBITER_WAW_EN blocks issue that would overtake a pending same-dest write.
module wb_slot_arbiter
  import wb_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_STAGES = 4,
  parameter int DEST_SIZE  = 5,
  parameter int LATENCY [NUM_REQ] = DEFAULT_LATENCY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DEST_SIZE-1:0]   req_dest,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           wb_valid,
  output logic [DEST_SIZE-1:0]           wb_dest,
  output logic [$clog2(NUM_REQ)-1:0]     wb_src,
  output logic                           busy,
  input  logic [DEST_SIZE-1:0]           test_dest,
  output logic                           test_pending,
  output logic [15:0]                    conflict_count
);
  localparam int SRC_W = $clog2(NUM_REQ);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [NUM_STAGES-1:0]  slot_vld;
  logic [SLOT_DEST_W-1:0] slot_dest [NUM_STAGES];
  logic [SLOT_SRC_W-1:0]  slot_src  [NUM_STAGES];
  slot_entry              cur [NUM_STAGES];
  slot_entry              nxt [NUM_STAGES];

  logic [SLOT_DEST_W-1:0] req_dest_ext [NUM_REQ];
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant;
  logic [SRC_W-1:0]       ptr;
  logic [SRC_W-1:0]       gnt_idx;
  logic                   any_grant;

  always_comb begin
    for (int j = 0; j < NUM_STAGES; j++) begin
      cur[j].valid = slot_vld[j];
      cur[j].dest  = slot_dest[j];
      cur[j].src   = slot_src[j];
    end
  end

  // Eligibility: the target slot must be free once the table has shifted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    localparam int LAT = LATENCY[gi];
    logic slot_free;
    logic waw_hit;

    assign req_dest_ext[gi] = SLOT_DEST_W'(req_dest[gi*DEST_SIZE +: DEST_SIZE]);

    if (LAT == NUM_STAGES) begin : g_top
      assign slot_free = 1'b1;
    end else begin : g_mid
      assign slot_free = ~cur[LAT].valid;
    end

`ifdef WB_SLOT_ARBITER_WAW_EN
    always_comb begin
      waw_hit = 1'b0;
      for (int j = LAT + 1; j < NUM_STAGES; j++)
        if (cur[j].valid && (cur[j].dest == req_dest_ext[gi]))
          waw_hit = 1'b1;
    end
`else
    assign waw_hit = 1'b0;
`endif

    assign eligible[gi] = req_valid[gi] & ~hold & ~reset & slot_free & ~waw_hit;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (SRC_W)
  ) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant)
  );

  always_comb begin
    any_grant = |grant;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gnt_idx = SRC_W'(i);
  end

  always_comb begin
    for (int j = 0; j < NUM_STAGES; j++)
      nxt[j] = cur[j];
    if (!hold) begin
      for (int j = 0; j < NUM_STAGES - 1; j++)
        nxt[j] = cur[j+1];
      nxt[NUM_STAGES-1] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          nxt[LATENCY[i]-1].valid = 1'b1;
          nxt[LATENCY[i]-1].dest  = req_dest_ext[i];
          nxt[LATENCY[i]-1].src   = SLOT_SRC_W'(i);
        end
      end
    end
  end

  // Slot table register: valids are reset, payload is not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld <= '0;
    end else begin
      for (int j = 0; j < NUM_STAGES; j++)
        slot_vld[j] <= nxt[j].valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_STAGES; j++) begin
      slot_dest[j] <= nxt[j].dest;
      slot_src[j]  <= nxt[j].src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      conflict_count <= '0;
    end else begin
      if (any_grant)
        ptr <= (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (!hold && (|req_valid) && !any_grant)
        conflict_count <= sat_inc16(conflict_count);
    end
  end

  always_comb begin
    test_pending = 1'b0;
    for (int j = 0; j < NUM_STAGES; j++)
      if (cur[j].valid && (cur[j].dest == SLOT_DEST_W'(test_dest)))
        test_pending = 1'b1;
  end

  assign req_ready = grant;
  assign wb_valid  = cur[0].valid;
  assign wb_dest   = DEST_SIZE'(cur[0].dest);
  assign wb_src    = SRC_W'(cur[0].src);
  assign busy      = |slot_vld;
endmodule
